// File: rtl/sfx_tone_player_if.sv
// Event and audio bundle between the volume display stage, the tone player and the codec side.
interface sfx_tone_player_if;
  logic        sound_en;
  logic        step_trig;
  logic        shot_trig;
  logic        hit_trig;
  logic        tone_out;
  logic [15:0] audio_sample;
  logic        busy;
  logic [1:0]  effect_id;

  modport master (
    output sound_en, step_trig, shot_trig, hit_trig,
    input  tone_out, audio_sample, busy, effect_id
  );

  modport slave (
    input  sound_en, step_trig, shot_trig, hit_trig,
    output tone_out, audio_sample, busy, effect_id
  );
endinterface

// File: rtl/sfx_tone_player.sv
// Square-wave sound effect sequencer: three prioritised 4-note effects,
// each note followed by a silent gap, muted and held idle while sound_en is low.
module sfx_tone_player #(
  parameter int unsigned NOTE_CYCLES = 3_000_000,
  parameter int unsigned GAP_CYCLES  = 500_000,
  parameter int unsigned TONE_UNIT   = 25,
  parameter logic [15:0] AMPLITUDE   = 16'h2000
) (
  input logic              clk,
  input logic              reset,
  sfx_tone_player_if.slave sfx
);

  typedef enum logic [1:0] {
    IDLE,
    NOTE,
    GAP
  } state_e;

  localparam logic [31:0] NOTE_LAST     = 32'(NOTE_CYCLES - 1);
  localparam logic [31:0] GAP_LAST      = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] UNIT          = 32'(TONE_UNIT);
  localparam logic [15:0] NEG_AMPLITUDE = ~AMPLITUDE + 16'd1;

  state_e      state_q, state_d;
  logic [1:0]  effectId_q, effectId_d;
  logic [1:0]  noteIdx_q, noteIdx_d;
  logic [31:0] durCnt_q, durCnt_d;
  logic [31:0] gapCnt_q, gapCnt_d;
  logic [31:0] phCnt_q, phCnt_d;
  logic        tone_q, tone_d;
  logic [15:0] sample_q, sample_d;
  logic        busy_q, busy_d;

  // Trigger levels as {hit, shot, step}: sampled copy and the copy one cycle older.
  logic [2:0]  trigS_q;
  logic [2:0]  trigPrev_q;
  logic [1:0]  warm_q;

  logic [2:0]  trigRise;
  logic [1:0]  riseId;
  logic        startReq;
  logic [31:0] hpCur;

  // Half-period of a note in TONE_UNIT units; 0 marks a rest.
  function automatic logic [31:0] halfPeriodUnits(input logic [1:0] id, input logic [1:0] idx);
    logic [31:0] units;
    units = 32'd0;
    case (id)
      2'd1: units = (idx < 2'd2) ? 32'd3200 : 32'd0;
      2'd2: begin
        case (idx)
          2'd0:    units = 32'd1000;
          2'd1:    units = 32'd1250;
          2'd2:    units = 32'd1500;
          default: units = 32'd2000;
        endcase
      end
      2'd3: units = idx[0] ? 32'd5000 : 32'd4000;
      default: units = 32'd0;
    endcase
    return units;
  endfunction

  // Rises are only trusted once both history registers hold post-reset samples,
  // so a trigger that was already high through reset counts as a level, not an event.
  assign trigRise = (warm_q == 2'd2) ? (trigS_q & ~trigPrev_q) : 3'b000;
  assign riseId   = trigRise[2] ? 2'd3 :
                    trigRise[1] ? 2'd2 :
                    trigRise[0] ? 2'd1 : 2'd0;
  assign startReq = (riseId != 2'd0) && ((state_q == IDLE) || (riseId > effectId_q));
  assign hpCur    = halfPeriodUnits(effectId_q, noteIdx_q) * UNIT;

  // Next-state logic: mute beats start, start beats normal note/gap sequencing.
  always_comb begin
    state_d    = state_q;
    effectId_d = effectId_q;
    noteIdx_d  = noteIdx_q;
    durCnt_d   = durCnt_q;
    gapCnt_d   = gapCnt_q;
    phCnt_d    = phCnt_q;
    tone_d     = tone_q;
    sample_d   = 16'd0;
    busy_d     = 1'b0;

    if (!sfx.sound_en) begin
      state_d    = IDLE;
      effectId_d = 2'd0;
      noteIdx_d  = 2'd0;
      durCnt_d   = 32'd0;
      gapCnt_d   = 32'd0;
      phCnt_d    = 32'd0;
      tone_d     = 1'b0;
    end else if (startReq) begin
      state_d    = NOTE;
      effectId_d = riseId;
      noteIdx_d  = 2'd0;
      durCnt_d   = 32'd0;
      gapCnt_d   = 32'd0;
      phCnt_d    = 32'd0;
      tone_d     = (halfPeriodUnits(riseId, 2'd0) != 32'd0);
    end else begin
      case (state_q)
        NOTE: begin
          if (hpCur != 32'd0) begin
            if (phCnt_q == hpCur - 32'd1) begin
              phCnt_d = 32'd0;
              tone_d  = ~tone_q;
            end else begin
              phCnt_d = phCnt_q + 32'd1;
            end
          end
          if (durCnt_q == NOTE_LAST) begin
            state_d  = GAP;
            durCnt_d = 32'd0;
            phCnt_d  = 32'd0;
            gapCnt_d = 32'd0;
            tone_d   = 1'b0;
          end else begin
            durCnt_d = durCnt_q + 32'd1;
          end
        end
        GAP: begin
          tone_d = 1'b0;
          if (gapCnt_q == GAP_LAST) begin
            gapCnt_d = 32'd0;
            if (noteIdx_q == 2'd3) begin
              state_d    = IDLE;
              effectId_d = 2'd0;
              noteIdx_d  = 2'd0;
            end else begin
              state_d   = NOTE;
              noteIdx_d = noteIdx_q + 2'd1;
              tone_d    = (halfPeriodUnits(effectId_q, noteIdx_q + 2'd1) != 32'd0);
            end
          end else begin
            gapCnt_d = gapCnt_q + 32'd1;
          end
        end
        default: begin
          tone_d = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
    if ((state_d == NOTE) && (halfPeriodUnits(effectId_d, noteIdx_d) != 32'd0)) begin
      sample_d = tone_d ? AMPLITUDE : NEG_AMPLITUDE;
    end
  end

  // State, counters, registered outputs and trigger history; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      effectId_q <= 2'd0;
      noteIdx_q  <= 2'd0;
      durCnt_q   <= 32'd0;
      gapCnt_q   <= 32'd0;
      phCnt_q    <= 32'd0;
      tone_q     <= 1'b0;
      sample_q   <= 16'd0;
      busy_q     <= 1'b0;
      trigS_q    <= 3'b000;
      trigPrev_q <= 3'b000;
      warm_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      effectId_q <= effectId_d;
      noteIdx_q  <= noteIdx_d;
      durCnt_q   <= durCnt_d;
      gapCnt_q   <= gapCnt_d;
      phCnt_q    <= phCnt_d;
      tone_q     <= tone_d;
      sample_q   <= sample_d;
      busy_q     <= busy_d;
      trigS_q    <= {sfx.hit_trig, sfx.shot_trig, sfx.step_trig};
      trigPrev_q <= trigS_q;
      if (warm_q != 2'd2) begin
        warm_q <= warm_q + 2'd1;
      end
    end
  end

  assign sfx.tone_out     = tone_q;
  assign sfx.audio_sample = sample_q;
  assign sfx.busy         = busy_q;
  assign sfx.effect_id    = effectId_q;

endmodule

// File: doc/sfx_tone_player.md
Name: sfx_tone_player

Overview:
- Sits directly downstream of the volume on/off display stage. It consumes that stage's sound_en and game-event pulses, and produces the square-wave audio sample fed to the audio codec interface.
- Plays one of three fixed 4-note sound effects (invader step, player shot, invader hit).
- Effects are prioritised, and a higher-priority effect pre-empts a lower one.
- While sound_en is low, all audio is muted and the sequencer is held idle.

Parameters:
NOTE_CYCLES, 3_000_000, duration of each note slot in clk cycles (60 ms at 50 MHz)
GAP_CYCLES, 500_000, silent gap after each note in clk cycles
TONE_UNIT, 25, clk cycles per half-period table unit
AMPLITUDE, 16'h2000, magnitude of the output sample when the tone is active

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
sound_en  input  1  audio enable from the volume display stage; 0 = muted/abort
step_trig  input  1  invader step event, rising-edge detected
shot_trig  input  1  player shot event, rising-edge detected
hit_trig  input  1  invader hit event, rising-edge detected
tone_out  output  1  raw square wave
audio_sample  output  16  signed sample: +AMPLITUDE / -AMPLITUDE / 0
busy  output  1  an effect is playing (state != IDLE)
effect_id  output  2  0 none, 1 step, 2 shot, 3 hit

Behaviour:
- Reset: state IDLE; tone_out=0, audio_sample=0, busy=0, effect_id=0. All counters and edge-detect registers are 0.
- Edge detect:
  - trig_rise = trig & ~trig_d, where trig_d is registered every cycle.
  - A trigger held high starts at most one effect.
- Priority: hit(3) > shot(2) > step(1). Simultaneous rises select the highest.
- Start rules:
  - A rise with id > effect_id, or any rise while IDLE, restarts the sequencer at the next edge: state NOTE, note_idx=0, counters cleared.
  - A rise with id <= current effect_id while busy is ignored.
- Half-period table, in TONE_UNIT units (0 = rest):
  - step: 3200, 3200, 0, 0
  - shot: 1000, 1250, 1500, 2000
  - hit: 4000, 5000, 4000, 5000
- hp = table × TONE_UNIT. This needs 32-bit arithmetic; no truncation is permitted.
- State machine:
  - IDLE: waits for a start.
  - NOTE:
    - dur_cnt counts 0..NOTE_CYCLES-1.
    - ph_cnt counts 0..hp-1; at hp-1 it wraps to 0 and tone toggles.
    - tone starts at 1 on the first NOTE cycle of every note.
    - When dur_cnt = NOTE_CYCLES-1, go to GAP.
  - GAP:
    - tone forced to 0; gap_cnt counts 0..GAP_CYCLES-1.
    - At the end: if note_idx=3, go to IDLE and set effect_id=0; else note_idx+1, go to NOTE.
- Rest note (hp=0): tone held 0 for the whole NOTE slot, no toggling. Timing is unchanged.
- Outputs, all registered:
  - audio_sample = +AMPLITUDE if tone=1, or -AMPLITUDE (two's complement) if tone=0, while in a non-rest NOTE state.
  - Otherwise audio_sample = 0. tone_out mirrors tone.
- Latency:
  - A trigger sampled high at edge k (with trig_d=0) gives busy=1, effect_id set, tone_out=1 and audio_sample=+AMPLITUDE after edge k+1.
  - Total effect length = 4×(NOTE_CYCLES+GAP_CYCLES) cycles; busy drops on the edge after the final GAP cycle.
- sound_en=0:
  - At the next edge: state IDLE, outputs 0, effect_id=0.
  - Triggers are ignored while sound_en=0. Edge-detect registers still update, so a trigger held high across re-enable does not fire.
- reset mid-effect: immediate return to reset values at that edge. reset has priority over everything.

Test Plan:
- Use TONE_UNIT=1, NOTE_CYCLES=5000, GAP_CYCLES=100 throughout.
- Reset: assert reset 3 cycles with triggers high -> all outputs 0, busy=0; with triggers still high after release, no effect starts.
- Shot: 1-cycle shot_trig pulse, sound_en=1:
  - busy=1 and effect_id=2 one cycle later.
  - tone_out toggles every 1000 cycles in note 0 and every 1250 in note 1.
  - audio_sample is ±16'h2000 in NOTE and 0 in GAP.
  - busy falls exactly 20400 cycles after start.
- Pre-emption: shot playing, hit_trig pulse at note 2 -> next cycle effect_id=3, note_idx=0, tone period 4000 half-cycles. A later step_trig pulse is ignored and effect_id stays 3.
- Simultaneous step, shot and hit rises in the same cycle -> effect_id=3.
- Mute: sound_en dropped mid-note -> next cycle busy=0, audio_sample=0. shot_trig pulse while sound_en=0 -> no start.
- Step rest notes: step effect -> notes 2-3 keep audio_sample=0 and tone_out=0 for 5000 cycles each, and busy stays 1 until 20400 cycles.
